// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier control path.
package booth_pkg;

  localparam int N_DEFAULT  = 16;
  localparam int CW_DEFAULT = 5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    EVAL   = 3'd3,
    ADD    = 3'd4,
    SUB    = 3'd5,
    SHIFT  = 3'd6,
    DONE   = 3'd7
  } state_e;

  typedef struct packed {
    logic ld_m;
    logic clr_a;
    logic ld_q;
    logic clr_qm1;
    logic ld_a;
    logic addsub;
    logic sft;
    logic busy;
    logic done;
  } strobes_t;

  // Moore output decode; anything not listed leaves every strobe low.
  function automatic strobes_t decode_state(input state_e s);
    strobes_t o;
    o = '0;
    case (s)
      IDLE:   o = '0;
      LOAD_M: begin o.ld_m = 1'b1; o.clr_a = 1'b1; o.clr_qm1 = 1'b1; o.busy = 1'b1; end
      LOAD_Q: begin o.ld_q = 1'b1; o.busy = 1'b1; end
      EVAL:   o.busy = 1'b1;
      ADD:    begin o.ld_a = 1'b1; o.addsub = OP_ADD; o.busy = 1'b1; end
      SUB:    begin o.ld_a = 1'b1; o.addsub = OP_SUB; o.busy = 1'b1; end
      SHIFT:  begin o.sft = 1'b1; o.busy = 1'b1; end
      DONE:   begin o.done = 1'b1; o.busy = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/booth_counter.sv
// Loadable iteration down-counter; saturates at zero so it never wraps.
module booth_counter
  import booth_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          is_one
);

  logic [CW-1:0] cnt_r;

  // Counter register: clear beats load, load beats decrement.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= CW'(N);
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt    = cnt_r;
  assign is_one = (cnt_r == CW'(1));

endmodule

// File: rtl/booth_ctrl.sv
// Control FSM for the radix-2 Booth multiplier: load, evaluate, add/sub, shift, done.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  input  logic          q0,
  input  logic          qm1,
  output logic          ld_m,
  output logic          clr_a,
  output logic          ld_q,
  output logic          clr_qm1,
  output logic          ld_a,
  output logic          addsub,
  output logic          sft,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  state_e   state_r;
  state_e   next_state_s;
  strobes_t out_r;
  logic     is_one_s;

  booth_counter #(.N(N), .CW(CW)) u_counter (
    .clk    (clk),
    .clear  (clear),
    .load   (state_r == LOAD_M),
    .dec    (state_r == SHIFT),
    .cnt    (cnt),
    .is_one (is_one_s)
  );

  // Next-state logic; q0/qm1 only matter in EVAL.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE:   next_state_s = start ? LOAD_M : IDLE;
      LOAD_M: next_state_s = LOAD_Q;
      LOAD_Q: next_state_s = EVAL;
      EVAL: begin
        case ({q0, qm1})
          2'b10:   next_state_s = SUB;
          2'b01:   next_state_s = ADD;
          default: next_state_s = SHIFT;
        endcase
      end
      ADD:    next_state_s = SHIFT;
      SUB:    next_state_s = SHIFT;
      SHIFT:  next_state_s = is_one_s ? DONE : EVAL;
      DONE:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register plus outputs pre-decoded from the next state, so they track state_r.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r <= IDLE;
      out_r   <= '0;
    end else begin
      state_r <= next_state_s;
      out_r   <= decode_state(next_state_s);
    end
  end

  assign ld_m    = out_r.ld_m;
  assign clr_a   = out_r.clr_a;
  assign ld_q    = out_r.ld_q;
  assign clr_qm1 = out_r.clr_qm1;
  assign ld_a    = out_r.ld_a;
  assign addsub  = out_r.addsub;
  assign sft     = out_r.sft;
  assign busy    = out_r.busy;
  assign done    = out_r.done;

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl driving a behavioural Booth datapath model.
module tb_booth_ctrl;
  import booth_pkg::*;

  localparam int N  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          clear, start;
  logic          q0, qm1;
  logic          ld_m, clr_a, ld_q, clr_qm1, ld_a, addsub, sft, busy, done;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_bus, q_bus;
  logic [15:0] mm, ma, mq;
  logic        mqm1;

  booth_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .clear(clear), .start(start), .q0(q0), .qm1(qm1),
    .ld_m(ld_m), .clr_a(clr_a), .ld_q(ld_q), .clr_qm1(clr_qm1),
    .ld_a(ld_a), .addsub(addsub), .sft(sft), .busy(busy), .done(done), .cnt(cnt)
  );

  always #5 clk = ~clk;

  assign q0  = mq[0];
  assign qm1 = mqm1;

  // Behavioural datapath reacting to the strobes on the edge that ends each state.
  always @(posedge clk) begin
    if (ld_m)    mm <= m_bus;
    if (ld_q)    mq <= q_bus;
    if (clr_a)   ma <= 16'd0;
    if (clr_qm1) mqm1 <= 1'b0;
    if (ld_a)    ma <= addsub ? (ma - mm) : (ma + mm);
    if (sft)     {ma, mq, mqm1} <= {ma[15], ma, mq};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] all_outs();
    return {ld_m, clr_a, ld_q, clr_qm1, ld_a, addsub, sft, busy, done};
  endfunction

  // One multiply from start to done; optional start pulse in cycle 10 or start held throughout.
  task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] q,
                        input int exp_cyc, input int exp_k, input logic [31:0] exp_prod,
                        input bit pulse10, input bit hold);
    int cyc, k, exp_cnt;
    bit busy_ok, cnt_ok, excl_ok;
    @(negedge clk);
    m_bus = m; q_bus = q; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check({tag, " ld_m cycle1"}, 64'(ld_m), 64'd1);
    cyc = 1; k = 0; exp_cnt = N; busy_ok = 1'b1; cnt_ok = 1'b1; excl_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (ld_a) k++;
      if (sft) begin
        if (cnt !== CW'(exp_cnt)) cnt_ok = 1'b0;
        exp_cnt--;
      end
      if (sft && ld_a) excl_ok = 1'b0;
      if (addsub && !ld_a) excl_ok = 1'b0;
      if (pulse10 && cyc == 10) start = 1'b1;
      else if (!hold) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " add/sub visits"}, 64'(k), 64'(exp_k));
    check({tag, " product"}, 64'({ma, mq}), 64'(exp_prod));
    check({tag, " busy throughout"}, 64'({busy_ok, busy}), 64'b11);
    check({tag, " cnt sequence"}, 64'(cnt_ok), 64'd1);
    check({tag, " cnt at done"}, 64'(cnt), 64'd0);
    check({tag, " strobe exclusivity"}, 64'(excl_ok), 64'd1);
    @(negedge clk);
    check({tag, " idle after done"}, 64'(all_outs()), 64'd0);
    if (hold) begin
      @(negedge clk);
      check({tag, " reissue LOAD_M"}, 64'(ld_m), 64'd1);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check({tag, " reissue done cycle"}, 64'(cyc), 64'(exp_cyc));
      check({tag, " reissue product"}, 64'({ma, mq}), 64'(exp_prod));
      @(negedge clk);
    end
  endtask

  initial begin
    int subs, guard;
    bit no_done;
    clear = 1'b1; start = 1'b0; m_bus = 16'd0; q_bus = 16'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs", 64'(all_outs()), 64'd0);
    check("reset cnt", 64'(cnt), 64'd0);
    clear = 1'b0;
    @(negedge clk);
    check("idle without start", 64'(all_outs()), 64'd0);

    run_op("q0m7", 16'd7, 16'd0, 35, 0, 32'h0000_0000, 1'b0, 1'b0);
    run_op("m-3q7", 16'hFFFD, 16'd7, 37, 2, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op("q5555", 16'd3, 16'h5555, 51, 16, 32'h0000_FFFF, 1'b0, 1'b0);
    run_op("pulse10", 16'hFFFD, 16'd7, 37, 2, 32'hFFFF_FFEB, 1'b1, 1'b0);
    run_op("hold", 16'd7, 16'd0, 35, 0, 32'h0000_0000, 1'b0, 1'b1);

    // Abort in the SUB visit of iteration 5 (third SUB for Q=5555).
    @(negedge clk);
    m_bus = 16'd3; q_bus = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    subs = 0; guard = 0;
    while (subs < 3 && guard < 100) begin
      if (ld_a && addsub) subs++;
      if (subs < 3) @(negedge clk);
      guard++;
    end
    check("clear reached SUB5", 64'({ld_a, addsub}), 64'b11);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear outputs", 64'(all_outs()), 64'd0);
    check("clear cnt", 64'(cnt), 64'd0);
    check("clear state", 64'(dut.state_r), 64'(IDLE));
    no_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    check("no done after clear", 64'(no_done), 64'd1);
    run_op("after clear", 16'hFFFD, 16'd7, 37, 2, 32'hFFFF_FFEB, 1'b0, 1'b0);

    // Jam the state register mid-operation; the FSM must fall back to IDLE in one cycle.
    @(negedge clk);
    m_bus = 16'd7; q_bus = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    force dut.state_r = DONE;
    #1;
    release dut.state_r;
    @(negedge clk);
    check("jam state idle", 64'(dut.state_r), 64'(IDLE));
    check("jam outputs", 64'(all_outs()), 64'd0);
    @(negedge clk);
    check("jam stays idle", 64'(all_outs()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
